// File: rtl/ro_sweep_pkg.sv
// ro_sweep_pkg: shared types, constants and source-selection helpers for the
// ring-oscillator sweep sequencer.
package ro_sweep_pkg;

  localparam int N_SRC     = 8;
  localparam int CFG_W     = 12;
  localparam int SHIFT_CYC = 2 * CFG_W;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETTLE,
    MEASURE,
    REPORT,
    DONE
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } src_sel_t;

  // Lowest set bit of mask strictly above cur.
  function automatic src_sel_t next_src(input logic [N_SRC-1:0] mask,
                                        input logic [2:0]       cur);
    src_sel_t r;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

  // Lowest set bit of mask.
  function automatic src_sel_t first_src(input logic [N_SRC-1:0] mask);
    src_sel_t r;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: two-flop synchronizer for an asynchronous clock-like input,
// followed by a one-cycle rising-edge pulse in the clk domain.
module ro_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  // [0],[1] are the metastability flops, [2] holds the previous synced level.
  logic [2:0] sync_q;

  // Shift the asynchronous level through the synchronizer chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], async_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ro_sweep_ctrl.sv
// ro_sweep_ctrl: loads the RO config shifter, then measures each enabled
// oscillator source over a fixed window and reports one count per source.
// Optional feature: define RO_SWEEP_MINMAX_EN to add running min/max outputs.
module ro_sweep_ctrl
  import ro_sweep_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic [N_SRC-1:0] src_mask,
  input  logic             osc_in,
  output logic             shift_clk,
  output logic             shift_dta,
  output logic [2:0]       clk_source,
  output logic             ro_en,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_src,
  output logic [CNT_W-1:0] res_count,
  output logic             done
`ifdef RO_SWEEP_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count,
  output logic [2:0]       min_src,
  output logic [2:0]       max_src
`endif
);

  // One timer serves the shift, settle and window phases.
  localparam int TMR_W = $clog2(WIN_CYC + SETTLE_CYC + SHIFT_CYC) + 1;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [2:0]         src_q, src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rise;
  logic [3:0]         bit_idx;
  src_sel_t           sel;

  ro_edge_sync u_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .async_i (osc_in),
    .rise_o  (rise)
  );

  // Sequencer and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cfg_q   <= '0;
      mask_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cfg_q   <= cfg_d;
      mask_q  <= mask_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: phase timing, source stepping and edge counting.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cfg_d   = cfg_q;
    mask_d  = mask_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    sel     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d   = cfg_word;
          mask_d  = src_mask;
          tmr_d   = '0;
          state_d = (src_mask == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (tmr_q == TMR_W'(SHIFT_CYC - 1)) begin
          tmr_d   = '0;
          sel     = first_src(mask_q);
          src_d   = sel.idx;
          state_d = SETTLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = MEASURE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      MEASURE: begin
        if (rise && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        if (tmr_q == TMR_W'(WIN_CYC - 1)) begin
          tmr_d   = '0;
          state_d = REPORT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      REPORT: begin
        if (res_ready) begin
          sel = next_src(mask_q, src_q);
          if (sel.found) begin
            src_d   = sel.idx;
            state_d = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Two timer cycles per config bit: even = data setup, odd = clock high.
  assign bit_idx    = 4'(CFG_W - 1) - tmr_q[4:1];
  assign shift_clk  = (state_q == SHIFT) & tmr_q[0];
  assign shift_dta  = (state_q == SHIFT) & cfg_q[bit_idx];
  assign clk_source = src_q;
  assign ro_en      = (state_q == SHIFT) || (state_q == SETTLE) ||
                      (state_q == MEASURE) || (state_q == REPORT);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign res_valid  = (state_q == REPORT);
  assign res_src    = src_q;
  assign res_count  = cnt_q;

`ifdef RO_SWEEP_MINMAX_EN
  logic [CNT_W-1:0] min_q, max_q;
  logic [2:0]       min_src_q, max_src_q;
  logic             have_q;
  logic             hs;

  assign hs = (state_q == REPORT) && res_ready;

  // Running extremes over the sweep; strict compares keep the earlier source on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q     <= '0;
      max_q     <= '0;
      min_src_q <= '0;
      max_src_q <= '0;
      have_q    <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      min_q     <= '1;
      max_q     <= '0;
      min_src_q <= '0;
      max_src_q <= '0;
      have_q    <= 1'b0;
    end else if (hs) begin
      if (!have_q || (cnt_q < min_q)) begin
        min_q     <= cnt_q;
        min_src_q <= src_q;
      end
      if (!have_q || (cnt_q > max_q)) begin
        max_q     <= cnt_q;
        max_src_q <= src_q;
      end
      have_q <= 1'b1;
    end
  end

  assign min_count = min_q;
  assign max_count = max_q;
  assign min_src   = min_src_q;
  assign max_src   = max_src_q;
`endif

endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// tb_ro_sweep_ctrl: randomized bench for ro_sweep_ctrl with a behavioural
// timeline model. Two instances share all inputs: a 16-bit counter and a
// 4-bit counter that saturates. Define RO_SWEEP_MINMAX_EN to check min/max.
module tb_ro_sweep_ctrl;

  localparam int CNT_W  = 16;
  localparam int CNT_WB = 4;
  localparam int WIN    = 1024;
  localparam int SETL   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        osc_in = 1'b0;
  logic        res_ready = 1'b1;
  logic [11:0] cfg_word = '0;
  logic [7:0]  src_mask = '0;

  logic a_shift_clk, a_shift_dta, a_ro_en, a_busy, a_res_valid, a_done;
  logic [2:0] a_clk_source, a_res_src;
  logic [CNT_W-1:0] a_res_count;
  logic b_shift_clk, b_shift_dta, b_ro_en, b_busy, b_res_valid, b_done;
  logic [2:0] b_clk_source, b_res_src;
  logic [CNT_WB-1:0] b_res_count;
`ifdef RO_SWEEP_MINMAX_EN
  logic [CNT_W-1:0] a_min_count, a_max_count;
  logic [2:0] a_min_src, a_max_src;
  logic [CNT_WB-1:0] b_min_count, b_max_count;
  logic [2:0] b_min_src, b_max_src;
`endif

  ro_sweep_ctrl #(.CNT_W(CNT_W), .WIN_CYC(WIN), .SETTLE_CYC(SETL)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .cfg_word(cfg_word), .src_mask(src_mask),
    .osc_in(osc_in), .shift_clk(a_shift_clk), .shift_dta(a_shift_dta),
    .clk_source(a_clk_source), .ro_en(a_ro_en), .busy(a_busy), .res_valid(a_res_valid),
    .res_ready(res_ready), .res_src(a_res_src), .res_count(a_res_count), .done(a_done)
`ifdef RO_SWEEP_MINMAX_EN
    , .min_count(a_min_count), .max_count(a_max_count), .min_src(a_min_src), .max_src(a_max_src)
`endif
  );

  ro_sweep_ctrl #(.CNT_W(CNT_WB), .WIN_CYC(WIN), .SETTLE_CYC(SETL)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .cfg_word(cfg_word), .src_mask(src_mask),
    .osc_in(osc_in), .shift_clk(b_shift_clk), .shift_dta(b_shift_dta),
    .clk_source(b_clk_source), .ro_en(b_ro_en), .busy(b_busy), .res_valid(b_res_valid),
    .res_ready(res_ready), .res_src(b_res_src), .res_count(b_res_count), .done(b_done)
`ifdef RO_SWEEP_MINMAX_EN
    , .min_count(b_min_count), .max_count(b_max_count), .min_src(b_min_src), .max_src(b_max_src)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d..%0d", nm, $time, act, lo, hi);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Oscillator stimulus: mode 0 = random level each cycle, N = square wave of period N clk.
  int osc_mode = 0;
  int osc_ph   = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (osc_mode == 0) osc_in = 1'($urandom_range(0, 1));
      else begin
        osc_in = ((osc_ph % osc_mode) < (osc_mode / 2));
        osc_ph++;
      end
    end
  end

  // Behavioural model: phase 0 idle, 1 shift, 2 settle, 3 window, 4 report, 5 done.
  int          ph, pt, ecnt;
  logic [2:0]  esrc;
  logic [11:0] ecfg;
  logic [3:0]  hist;
  int          q[$];
  int          emin, emax;
  logic [2:0]  emin_src, emax_src;
  bit          ehave;

  // Observations gathered for the scenario-level checks.
  logic [11:0] sh_bits;
  int          sh_n, dn_cnt;
  logic        prev_sclk;
  int          got_src[$], got_a[$], got_b[$];

  task automatic clear_caps();
    sh_bits = '0; sh_n = 0; dn_cnt = 0;
    got_src.delete(); got_a.delete(); got_b.delete();
  endtask

  task automatic mreset();
    ph = 0; pt = 0; ecnt = 0; esrc = '0; ecfg = '0; hist = '0;
    q.delete();
  endtask

  task automatic madvance();
    int c;
    // An osc level needs three clk edges to show up as a counted edge.
    hist = {hist[2:0], osc_in};
    case (ph)
      0: if (start) begin
        ecfg = cfg_word;
        q.delete();
        for (int i = 0; i < 8; i++) if (src_mask[i]) q.push_back(i);
        ph = (q.size() == 0) ? 5 : 1;
        pt = 0;
        emin = (1 << CNT_W) - 1; emax = 0; emin_src = '0; emax_src = '0; ehave = 0;
      end
      1: begin
        pt++;
        if (pt == 24) begin ph = 2; pt = 0; esrc = 3'(q[0]); end
      end
      2: begin
        pt++;
        if (pt == SETL) begin ph = 3; pt = 0; ecnt = 0; end
      end
      3: begin
        if (hist[2] && !hist[3]) ecnt++;
        pt++;
        if (pt == WIN) ph = 4;
      end
      4: if (res_ready) begin
        c = sat(ecnt, CNT_W);
        if (!ehave || c < emin) begin emin = c; emin_src = esrc; end
        if (!ehave || c > emax) begin emax = c; emax_src = esrc; end
        ehave = 1;
        void'(q.pop_front());
        if (q.size() > 0) begin esrc = 3'(q[0]); ph = 2; pt = 0; end
        else ph = 5;
      end
      default: ph = 0;
    endcase
  endtask

  task automatic compare();
    logic [4:0] ectl;
    if (rst) ectl = '0;
    else ectl = {ph != 0, (ph >= 1 && ph <= 4), ph == 5, ph == 4, (ph == 1) && (pt % 2 == 1)};
    chk("a_ctl", {a_busy, a_ro_en, a_done, a_res_valid, a_shift_clk}, ectl);
    chk("b_ctl", {b_busy, b_ro_en, b_done, b_res_valid, b_shift_clk}, ectl);
    chk("a_clk_source", a_clk_source, rst ? 3'd0 : esrc);
    chk("b_clk_source", b_clk_source, rst ? 3'd0 : esrc);
    if (rst) begin
      chk("a_shift_dta_rst", a_shift_dta, 0);
      chk("a_res_src_rst", a_res_src, 0);
      chk("a_res_count_rst", a_res_count, 0);
      chk("b_res_count_rst", b_res_count, 0);
    end else if (ph == 1) begin
      chk("a_shift_dta", a_shift_dta, ecfg[11 - pt / 2]);
      chk("b_shift_dta", b_shift_dta, ecfg[11 - pt / 2]);
    end else if (ph == 4) begin
      chk("a_res_src", a_res_src, esrc);
      chk("b_res_src", b_res_src, esrc);
      chk("a_res_count", a_res_count, sat(ecnt, CNT_W));
      chk("b_res_count", b_res_count, sat(ecnt, CNT_WB));
    end
`ifdef RO_SWEEP_MINMAX_EN
    if (!rst && ph == 5) begin
      chk("a_min_count", a_min_count, emin);
      chk("a_min_src", a_min_src, emin_src);
      chk("a_max_count", a_max_count, emax);
      chk("a_max_src", a_max_src, emax_src);
    end
`endif
    if (a_shift_clk && !prev_sclk) begin
      sh_bits = {sh_bits[10:0], a_shift_dta};
      sh_n++;
    end
    prev_sclk = a_shift_clk;
    if (a_done) dn_cnt++;
    if (a_res_valid && res_ready) begin
      got_src.push_back(int'(a_res_src));
      got_a.push_back(int'(a_res_count));
      got_b.push_back(int'(b_res_count));
    end
  endtask

  // Model advance on each active edge, compare mid-cycle.
  initial begin
    prev_sclk = 1'b0;
    clear_caps();
    mreset();
    forever begin
      @(posedge clk);
      if (rst) mreset();
      else madvance();
      @(negedge clk);
      if (rst) mreset();
      compare();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input bit inj,
                           output bit ok, output int n);
    ok = 0;
    n  = budget;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (a_done) begin ok = 1; n = cyc; break; end
      res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = inj && (cyc == 300 || cyc == 2500);
      if (start) begin cfg_word = 12'($urandom); src_mask = 8'($urandom); end
      step();
    end
    start = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic run_sweep(input logic [11:0] c, input logic [7:0] m, input bit rnd,
                           input bit inj, input string nm, output int n);
    bit ok;
    clear_caps();
    cfg_word = c; src_mask = m; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(12000, rnd, inj, ok, n);
    chk({nm, "_done_seen"}, ok, 1);
    step();
  endtask

  initial begin
    bit ok;
    int n;
    logic [7:0] m;

    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy", a_busy, 0);
    chk("rst_ro_en", a_ro_en, 0);
    rst = 1'b0;
    step();

    // Config shift order and clk/8 window count.
    osc_mode = 8;
    run_sweep(12'hA5C, 8'h01, 0, 0, "t1", n);
    chk("t1_shift_pulses", sh_n, 12);
    chk("t1_shift_bits", sh_bits, 12'hA5C);
    chk("t2_n_results", got_src.size(), 1);
    if (got_src.size() == 1) begin
      chk("t2_src", got_src[0], 0);
      chk_range("t2_count", got_a[0], 127, 129);
    end

    // Three sources in ascending order, single done, busy drops after it.
    osc_mode = 0;
    run_sweep(12'($urandom), 8'h85, 0, 0, "t3", n);
    chk("t3_busy_after_done", a_busy, 0);
    chk("t3_done_pulses", dn_cnt, 1);
    chk("t3_n_results", got_src.size(), 3);
    if (got_src.size() == 3) begin
      chk("t3_src0", got_src[0], 0);
      chk("t3_src1", got_src[1], 2);
      chk("t3_src2", got_src[2], 7);
    end

    // Consumer stall for 50 cycles in REPORT.
    clear_caps();
    osc_mode = 6;
    res_ready = 1'b0;
    cfg_word = 12'($urandom); src_mask = 8'h03; start = 1'b1;
    step();
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 1500; i++) begin
      if (a_res_valid) begin ok = 1; break; end
      step();
    end
    chk("t4_valid_reached", ok, 1);
    repeat (50) step();
    chk("t4_valid_held", a_res_valid, 1);
    chk("t4_src_held", a_res_src, 0);
    chk("t4_no_settle_yet", a_clk_source, 0);
    chk_range("t4_count_held", int'(a_res_count), 170, 171);
    res_ready = 1'b1;
    step();
    chk("t4_next_src", a_clk_source, 1);
    chk("t4_valid_dropped", a_res_valid, 0);
    wait_done(3000, 0, 0, ok, n);
    chk("t4_done_seen", ok, 1);
    step();

    // Saturation of the narrow counter at clk/4.
    osc_mode = 4;
    run_sweep(12'($urandom), 8'h01, 0, 0, "t5", n);
    chk("t5_n_results", got_src.size(), 1);
    if (got_src.size() == 1) begin
      chk("t5_b_saturated", got_b[0], 15);
      chk_range("t5_a_count", got_a[0], 255, 257);
    end

    // Empty mask: immediate done, no shifting.
    run_sweep(12'($urandom), 8'h00, 0, 0, "t5m0", n);
    chk("t5m0_latency", n, 0);
    chk("t5m0_done_pulses", dn_cnt, 1);
    chk("t5m0_no_shift", sh_n, 0);

    // Reset in the middle of a measurement window.
    clear_caps();
    osc_mode = 0;
    cfg_word = 12'($urandom); src_mask = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    repeat (24 + SETL + 200) step();
    chk("t6_measuring", a_ro_en, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ctl", {a_busy, a_ro_en, a_done, a_res_valid, a_shift_clk}, 0);
    chk("t6_rst_src", a_clk_source, 0);
    chk("t6_rst_count", a_res_count, 0);
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("t6_no_done_on_abort", dn_cnt, 0);
    m = 8'($urandom_range(1, 255));
    run_sweep(12'($urandom), m, 1, 1, "t6_rerun", n);
    chk("t6_n_results", got_src.size(), $countones(m));

    // Randomized sweeps with random consumer backpressure and dropped starts.
    for (int r = 0; r < 2; r++) begin
      osc_mode = (r == 0) ? 3 : 7;
      m = 8'($urandom_range(1, 255));
      run_sweep(12'($urandom), m, 1, 1, "rand", n);
      chk("rand_done_pulses", dn_cnt, 1);
      chk("rand_n_results", got_src.size(), $countones(m));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
